// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: stalls on a miss, writes back a dirty victim, refills the block word by word.
// Latency: clean miss costs WORDS+2 stalled cycles with zero-wait memory, plus WORDS for a dirty victim; memory waits via mem_ack.
module dcache_miss_ctrl #(
    parameter int WORDS = 4,
    parameter int CNT_W = 16,
    localparam int IW = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [31:0]      aluRslt,
    input  logic             hit,
    input  logic             dirty,
    input  logic [31:0]      victim_addr,
    input  logic [31:0]      wb_data,
    output logic             stall,
    output logic [IW-1:0]    wb_idx,
    output logic             fill_we,
    output logic [IW-1:0]    fill_idx,
    output logic [31:0]      fill_data,
    output logic             tag_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WB,
        S_FILL,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_cnt;
    logic [CNT_W-1:0] r_miss_count;

    logic        w_access;
    logic        w_miss;
    logic        w_last;
    logic [31:0] w_word_off;
    logic [31:0] w_blk_base;

    assign w_access   = MemRead | MemWrite;
    assign w_miss     = w_access & ~hit;
    assign w_last     = (r_cnt == IW'(WORDS - 1));
    assign w_word_off = {{(30 - IW){1'b0}}, r_cnt, 2'b00};
    assign w_blk_base = aluRslt & ~32'(WORDS * 4 - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_state <= dirty ? S_WB : S_FILL;
                        r_cnt   <= '0;
                        if (r_miss_count != '1)
                            r_miss_count <= r_miss_count + 1'b1;
                    end
                end
                S_WB: begin
                    if (mem_ack) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= S_FILL;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_FILL: begin
                    if (mem_ack) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last)
                            r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory-side outputs depend only on state and counter so they hold steady across wait cycles.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        wb_idx   = '0;
        fill_idx = '0;
        fill_we  = 1'b0;
        tag_we   = 1'b0;
        case (r_state)
            S_WB: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = victim_addr + w_word_off;
                wb_idx   = r_cnt;
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = w_blk_base | w_word_off;
                fill_idx = r_cnt;
                fill_we  = mem_ack;
            end
            S_DONE:  tag_we = 1'b1;
            default: ;
        endcase
    end

    assign stall      = (r_state != S_IDLE) | w_miss;
    assign fill_data  = mem_rdata;
    assign mem_wdata  = wb_data;
    assign miss_count = r_miss_count;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl; a second instance with a 2-bit counter covers saturation.
module tb_dcache_miss_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0, hit = 1'b0, dirty = 1'b0, mem_ack = 1'b0;
    logic [31:0] aluRslt = '0, victim_addr = '0, mem_rdata = '0;
    logic [31:0] wb_data;

    logic        stall, fill_we, tag_we, mem_req, mem_we;
    logic [1:0]  wb_idx, fill_idx;
    logic [31:0] fill_data, mem_addr, mem_wdata;
    logic [15:0] miss_count;

    logic        s_stall, s_fill_we, s_tag_we, s_mem_req, s_mem_we;
    logic [1:0]  s_wb_idx, s_fill_idx;
    logic [31:0] s_fill_data, s_mem_addr, s_mem_wdata;
    logic [1:0]  s_miss_count;

    int checks = 0;
    int errors = 0;
    int stall_cycles;

    always #5 clk = ~clk;

    // Cache model: victim word k reads as 0x5000+k.
    assign wb_data = 32'h5000 + {30'b0, wb_idx};

    dcache_miss_ctrl #(.WORDS(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .aluRslt(aluRslt), .hit(hit), .dirty(dirty), .victim_addr(victim_addr),
        .wb_data(wb_data), .stall(stall), .wb_idx(wb_idx), .fill_we(fill_we),
        .fill_idx(fill_idx), .fill_data(fill_data), .tag_we(tag_we),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .miss_count(miss_count)
    );

    dcache_miss_ctrl #(.WORDS(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .aluRslt(aluRslt), .hit(hit), .dirty(dirty), .victim_addr(victim_addr),
        .wb_data(wb_data), .stall(s_stall), .wb_idx(s_wb_idx), .fill_we(s_fill_we),
        .fill_idx(s_fill_idx), .fill_data(s_fill_data), .tag_we(s_tag_we),
        .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .miss_count(s_miss_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One acked FILL cycle for word k of the block at base.
    task automatic fill_cycle(input int k, input logic [31:0] base);
        mem_rdata = 32'hA0 + k;
        @(negedge clk);
        chk("fill_req", {31'b0, mem_req}, 32'd1);
        chk("fill_we_lvl", {31'b0, mem_we}, 32'd0);
        chk("fill_addr", mem_addr, base + 32'(4 * k));
        chk("fill_we", {31'b0, fill_we}, 32'd1);
        chk("fill_idx", {30'b0, fill_idx}, 32'(k));
        chk("fill_data", fill_data, 32'hA0 + k);
        chk("fill_stall", {31'b0, stall}, 32'd1);
        next_cycle();
    endtask

    // Miss detect cycle, then DONE and the retried hit after the fill words.
    task automatic miss_cycle();
        @(negedge clk);
        chk("miss_stall", {31'b0, stall}, 32'd1);
        chk("miss_noreq", {31'b0, mem_req}, 32'd0);
        next_cycle();
    endtask

    task automatic done_and_hit();
        @(negedge clk);
        chk("done_tag_we", {31'b0, tag_we}, 32'd1);
        chk("done_stall", {31'b0, stall}, 32'd1);
        chk("done_noreq", {31'b0, mem_req}, 32'd0);
        next_cycle();
        hit = 1'b1;
        @(negedge clk);
        chk("retry_stall", {31'b0, stall}, 32'd0);
        chk("retry_tag_we", {31'b0, tag_we}, 32'd0);
        next_cycle();
        MemRead = 1'b0; MemWrite = 1'b0; hit = 1'b0; dirty = 1'b0;
    endtask

    task automatic clean_miss(input logic [31:0] addr);
        MemRead = 1'b1; hit = 1'b0; dirty = 1'b0; mem_ack = 1'b1; aluRslt = addr;
        miss_cycle();
        for (int k = 0; k < 4; k++) fill_cycle(k, addr & 32'hFFFF_FFF0);
        done_and_hit();
    endtask

    initial begin
        // Reset state.
        #2;
        @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_fill_we", {31'b0, fill_we}, 32'd0);
        chk("rst_tag_we", {31'b0, tag_we}, 32'd0);
        chk("rst_idx", {28'b0, wb_idx, fill_idx}, 32'd0);
        chk("rst_cnt", {16'b0, miss_count}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        MemRead = 1'b1; hit = 1'b1; aluRslt = 32'h34;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hit_stall", {31'b0, stall}, 32'd0);
            chk("hit_req", {31'b0, mem_req}, 32'd0);
            next_cycle();
        end
        chk("hit_cnt", {16'b0, miss_count}, 32'd0);
        MemRead = 1'b0; hit = 1'b0;

        // Clean read miss, zero-wait memory.
        clean_miss(32'h34);
        chk("clean_cnt", {16'b0, miss_count}, 32'd1);

        // Dirty write miss: write back victim, then refill.
        MemWrite = 1'b1; hit = 1'b0; dirty = 1'b1; mem_ack = 1'b1;
        aluRslt = 32'h20; victim_addr = 32'h100;
        miss_cycle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("wb_req", {31'b0, mem_req}, 32'd1);
            chk("wb_we", {31'b0, mem_we}, 32'd1);
            chk("wb_addr", mem_addr, 32'h100 + 32'(4 * k));
            chk("wb_idx", {30'b0, wb_idx}, 32'(k));
            chk("wb_wdata", mem_wdata, 32'h5000 + 32'(k));
            chk("wb_fill_we", {31'b0, fill_we}, 32'd0);
            next_cycle();
        end
        for (int k = 0; k < 4; k++) fill_cycle(k, 32'h20);
        done_and_hit();
        chk("dirty_cnt", {16'b0, miss_count}, 32'd2);

        // Wait states: ack on every third cycle.
        MemRead = 1'b1; hit = 1'b0; dirty = 1'b0; mem_ack = 1'b0; aluRslt = 32'h44;
        stall_cycles = 0;
        @(negedge clk);
        if (stall) stall_cycles++;
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                mem_ack = (j == 2);
                mem_rdata = 32'hA0 + k;
                @(negedge clk);
                if (stall) stall_cycles++;
                chk("ws_req", {31'b0, mem_req}, 32'd1);
                chk("ws_we", {31'b0, mem_we}, 32'd0);
                chk("ws_addr", mem_addr, 32'h40 + 32'(4 * k));
                chk("ws_fill_we", {31'b0, fill_we}, {31'b0, mem_ack});
                next_cycle();
            end
        end
        mem_ack = 1'b0;
        @(negedge clk);
        if (stall) stall_cycles++;
        chk("ws_tag_we", {31'b0, tag_we}, 32'd1);
        next_cycle();
        hit = 1'b1;
        @(negedge clk);
        if (stall) stall_cycles++;
        next_cycle();
        chk("ws_stall_total", 32'(stall_cycles), 32'd14);
        chk("ws_cnt", {16'b0, miss_count}, 32'd3);
        MemRead = 1'b0; hit = 1'b0;

        // Reset during the second FILL word, then the held miss restarts.
        MemRead = 1'b1; hit = 1'b0; dirty = 1'b0; mem_ack = 1'b1; aluRslt = 32'h80;
        miss_cycle();
        fill_cycle(0, 32'h80);
        @(negedge clk);
        chk("pre_rst_idx", {30'b0, fill_idx}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_req", {31'b0, mem_req}, 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        chk("arst_fill_we", {31'b0, fill_we}, 32'd0);
        chk("arst_tag_we", {31'b0, tag_we}, 32'd0);
        chk("arst_stall", {31'b0, stall}, 32'd1);
        chk("arst_cnt", {16'b0, miss_count}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_tag_we", {31'b0, tag_we}, 32'd0);
        chk("rel_req", {31'b0, mem_req}, 32'd0);
        chk("rel_stall", {31'b0, stall}, 32'd1);
        next_cycle();
        for (int k = 0; k < 4; k++) fill_cycle(k, 32'h80);
        done_and_hit();
        chk("restart_cnt", {16'b0, miss_count}, 32'd1);
        chk("sat_cnt1", {30'b0, s_miss_count}, 32'd1);

        // Saturation on the 2-bit counter instance.
        clean_miss(32'h200);
        chk("sat_cnt2", {30'b0, s_miss_count}, 32'd2);
        clean_miss(32'h210);
        chk("sat_cnt3", {30'b0, s_miss_count}, 32'd3);
        clean_miss(32'h220);
        chk("sat_cnt4", {30'b0, s_miss_count}, 32'd3);
        clean_miss(32'h230);
        chk("sat_cnt5", {30'b0, s_miss_count}, 32'd3);
        chk("main_cnt5", {16'b0, miss_count}, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
